// File: rtl/lcd_text_refresh_if.sv
// Buffer read port and nibble-transfer handshake between the text refresher
// (master) and the character buffer / HD44780 nibble engine (slave).
interface lcd_text_refresh_if #(
    parameter int COLS = 16
);
    localparam int AW = 1 + $clog2(COLS);

    logic [AW-1:0] char_addr;
    logic [7:0]    char_data;
    logic          xfer_send;
    logic [4:0]    xfer_cmd;
    logic [20:0]   xfer_delay;
    logic          xfer_done;

    modport master (
        output char_addr, xfer_send, xfer_cmd, xfer_delay,
        input  char_data, xfer_done
    );

    modport slave (
        input  char_addr, xfer_send, xfer_cmd, xfer_delay,
        output char_data, xfer_done
    );
endinterface

// File: rtl/lcd_text_refresh.sv
// Post-init HD44780 4-bit refresher: redraws a 2 x COLS text buffer by sending
// Set-DDRAM-address and character bytes as high/low nibbles to the transfer engine.
module lcd_text_refresh #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int COLS         = 16,
    parameter int T_NIB_US     = 10,
    parameter int T_CMD_US     = 53,
    parameter bit AUTO_REFRESH = 1'b0
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               init_done,
    input  logic               refresh_req,
    lcd_text_refresh_if.master bus,
    output logic               busy,
    output logic               frame_done
);
    localparam int     CW         = $clog2(COLS);
    localparam longint CYC_PER_US = longint'(CLK_FREQ) / 64'sd1_000_000;
    localparam longint T_NIB_CLKS = CYC_PER_US * longint'(T_NIB_US);
    localparam longint T_CMD_CLKS = CYC_PER_US * longint'(T_CMD_US);
    localparam longint DELAY_MAX  = (64'sd1 <<< 21) - 64'sd1;
    localparam logic [20:0] T_NIB = T_NIB_CLKS[20:0];
    localparam logic [20:0] T_CMD = T_CMD_CLKS[20:0];
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    generate
        if (T_NIB_CLKS > DELAY_MAX || T_CMD_CLKS > DELAY_MAX || T_NIB_CLKS < 0 || T_CMD_CLKS < 0) begin : g_delay_overflow
            $error("lcd_text_refresh: nibble delay does not fit in 21 bits");
        end
        if (COLS < 2 || COLS > 64 || (COLS & (COLS - 1)) != 0) begin : g_bad_cols
            $error("lcd_text_refresh: COLS must be a power of 2 in 2..64");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_FETCH,
        S_CHAR_HI,
        S_CHAR_LO,
        S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic            line_reg, line_next;
    logic [CW-1:0]   col_reg, col_next;
    logic [7:0]      data_reg, data_next;
    logic            fetch_wait_reg, fetch_wait_next;
    logic            pending_reg, pending_next;
    logic            send_reg, send_next;
    logic [4:0]      cmd_reg, cmd_next;
    logic [20:0]     delay_reg, delay_next;
    logic            busy_reg, busy_next;
    logic            frame_done_reg, frame_done_next;
    logic [CW:0]     char_addr_reg, char_addr_next;
    logic [4:0]      launch_cmd;
    logic [20:0]     launch_delay;

    // Nibble and delay for whichever transfer state we are in.
    always_comb begin
        launch_cmd   = 5'b00000;
        launch_delay = T_CMD;
        case (state_reg)
            S_ADDR_HI: begin
                launch_cmd   = {2'b01, line_reg, 2'b00};
                launch_delay = T_NIB;
            end
            S_CHAR_HI: begin
                launch_cmd   = {1'b1, data_reg[7:4]};
                launch_delay = T_NIB;
            end
            S_CHAR_LO: launch_cmd = {1'b1, data_reg[3:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        line_next       = line_reg;
        col_next        = col_reg;
        data_next       = data_reg;
        fetch_wait_next = fetch_wait_reg;
        send_next       = send_reg;
        cmd_next        = cmd_reg;
        delay_next      = delay_reg;
        busy_next       = busy_reg;
        frame_done_next = 1'b0;

        case (state_reg)
            S_WAIT_INIT: begin
                if (init_done) state_next = S_IDLE;
            end
            S_IDLE: begin
                if (pending_reg || AUTO_REFRESH) begin
                    state_next = S_ADDR_HI;
                    busy_next  = 1'b1;
                    line_next  = 1'b0;
                    col_next   = '0;
                end
            end
            // A transfer state entered with send low spends one idle cycle, giving the
            // mandatory gap, then raises send; done is only honoured while send is high.
            S_ADDR_HI, S_ADDR_LO, S_CHAR_HI, S_CHAR_LO: begin
                if (!send_reg) begin
                    send_next  = 1'b1;
                    cmd_next   = launch_cmd;
                    delay_next = launch_delay;
                end else if (bus.xfer_done) begin
                    send_next = 1'b0;
                    if (state_reg == S_ADDR_HI) begin
                        state_next = S_ADDR_LO;
                    end else if (state_reg == S_ADDR_LO) begin
                        state_next      = S_FETCH;
                        fetch_wait_next = 1'b0;
                    end else if (state_reg == S_CHAR_HI) begin
                        state_next = S_CHAR_LO;
                    end else if (col_reg != COL_LAST) begin
                        col_next        = col_reg + CW'(1);
                        state_next      = S_FETCH;
                        fetch_wait_next = 1'b0;
                    end else if (!line_reg) begin
                        col_next   = '0;
                        line_next  = 1'b1;
                        state_next = S_ADDR_HI;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                // First cycle presents the address; second captures the byte and
                // launches the high nibble straight away.
                if (!fetch_wait_reg) begin
                    fetch_wait_next = 1'b1;
                end else begin
                    fetch_wait_next = 1'b0;
                    data_next       = bus.char_data;
                    send_next       = 1'b1;
                    cmd_next        = {1'b1, bus.char_data[7:4]};
                    delay_next      = T_NIB;
                    state_next      = S_CHAR_HI;
                end
            end
            S_DONE: begin
                frame_done_next = 1'b1;
                busy_next       = 1'b0;
                state_next      = S_IDLE;
            end
            default: state_next = S_WAIT_INIT;
        endcase

        pending_next = pending_reg;
        if (state_reg == S_IDLE && state_next == S_ADDR_HI) pending_next = 1'b0;
        if (refresh_req && state_reg != S_WAIT_INIT)        pending_next = 1'b1;

        char_addr_next = {line_next, col_next};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg      <= S_WAIT_INIT;
            line_reg       <= 1'b0;
            col_reg        <= '0;
            data_reg       <= 8'h00;
            fetch_wait_reg <= 1'b0;
            pending_reg    <= 1'b0;
            send_reg       <= 1'b0;
            cmd_reg        <= 5'b00000;
            delay_reg      <= 21'd0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            char_addr_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            line_reg       <= line_next;
            col_reg        <= col_next;
            data_reg       <= data_next;
            fetch_wait_reg <= fetch_wait_next;
            pending_reg    <= pending_next;
            send_reg       <= send_next;
            cmd_reg        <= cmd_next;
            delay_reg      <= delay_next;
            busy_reg       <= busy_next;
            frame_done_reg <= frame_done_next;
            char_addr_reg  <= char_addr_next;
        end
    end

    assign bus.char_addr  = char_addr_reg;
    assign bus.xfer_send  = send_reg;
    assign bus.xfer_cmd   = cmd_reg;
    assign bus.xfer_delay = delay_reg;
    assign busy           = busy_reg;
    assign frame_done     = frame_done_reg;
endmodule
